// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - CSR access bus between the execute stage and the CSR file
interface csr_file_if;
    logic        csr_en;
    logic        stall;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [4:0]  csr_rs1_idx;
    logic [31:0] csr_rs1_data;
    logic        retire;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] tohost;
    logic        test_done;

    modport master (
        output csr_en, stall, csr_funct3, csr_addr, csr_rs1_idx, csr_rs1_data, retire,
        input  csr_rdata, csr_illegal, tohost, test_done
    );

    modport slave (
        input  csr_en, stall, csr_funct3, csr_addr, csr_rs1_idx, csr_rs1_data, retire,
        output csr_rdata, csr_illegal, tohost, test_done
    );
endinterface

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode Zicsr CSR file with tohost, cycle/time and instret
module csr_file #(
    parameter logic [31:0] RESET_TOHOST = 32'h0000_0000
) (
    input logic       clk,
    input logic       rst,
    csr_file_if.slave bus
);
    localparam logic [11:0] ADDR_TOHOST    = 12'h51E;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_TIME      = 12'hC01;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_TIMEH     = 12'hC81;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    logic [31:0] r_tohost;
    logic        r_test_done;
    logic [63:0] r_cycle;
    logic [63:0] r_instret;

    logic [31:0] w_old;
    logic [31:0] w_src;
    logic [31:0] w_new;
    logic        w_known;
    logic        w_ro;
    logic        w_bad_funct3;
    logic        w_attempt;
    logic        w_illegal;
    logic        w_commit;

    // time has no separate timer here; it simply aliases cycle
    always_comb begin
        w_old   = 32'h0;
        w_known = 1'b1;
        w_ro    = 1'b1;
        case (bus.csr_addr)
            ADDR_TOHOST: begin
                w_old = r_tohost;
                w_ro  = 1'b0;
            end
            ADDR_CYCLE, ADDR_TIME:   w_old = r_cycle[31:0];
            ADDR_CYCLEH, ADDR_TIMEH: w_old = r_cycle[63:32];
            ADDR_INSTRET:            w_old = r_instret[31:0];
            ADDR_INSTRETH:           w_old = r_instret[63:32];
            default:                 w_known = 1'b0;
        endcase
    end

    assign w_bad_funct3 = (bus.csr_funct3[1:0] == 2'b00);
    assign w_src        = bus.csr_funct3[2] ? {27'b0, bus.csr_rs1_idx} : bus.csr_rs1_data;
    // set/clear with x0 or zimm=0 is a pure read, which keeps rdcycle legal on RO counters
    assign w_attempt    = (bus.csr_funct3[1:0] == 2'b01) || (bus.csr_rs1_idx != 5'd0);
    assign w_illegal    = bus.csr_en && (!w_known || w_bad_funct3 || (w_attempt && w_ro));
    assign w_commit     = bus.csr_en && !bus.stall && w_attempt && !w_illegal;

    always_comb begin
        w_new = w_src;
        case (bus.csr_funct3[1:0])
            2'b10:   w_new = w_old | w_src;
            2'b11:   w_new = w_old & ~w_src;
            default: w_new = w_src;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tohost    <= RESET_TOHOST;
            r_test_done <= RESET_TOHOST[0];
            r_cycle     <= 64'h0;
            r_instret   <= 64'h0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (bus.retire && !bus.stall) begin
                r_instret <= r_instret + 64'd1;
            end
            if (w_commit) begin
                r_tohost    <= w_new;
                r_test_done <= w_new[0];
            end
        end
    end

    assign bus.csr_rdata   = (bus.csr_en && !w_illegal) ? w_old : 32'h0;
    assign bus.csr_illegal = w_illegal;
    assign bus.tohost      = r_tohost;
    assign bus.test_done   = r_test_done;
endmodule
